// File: rtl/point_subtraction.sv
// point_subtraction: affine R = P - Q on y^2 = x^3 + ax + b over GF(p), via Q negation then add/double.
// Build option POINT_SUB_RANGE_CHECK_EN adds a range_err output and operand range checking at start.
module point_subtraction #(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] x2,
  input  logic [n-1:0] y2,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         result_ready,
  output logic         infinity,
`ifdef POINT_SUB_RANGE_CHECK_EN
  output logic         range_err,
`endif
  output logic         busy
);

  localparam int CW = $clog2(n + 1);
  localparam int IW = $clog2(2 * n + 2);

  typedef enum logic [3:0] {
    IDLE, NEG, CLASSIFY, INF, NUM, INV, LAMBDA, X3, Y3, DONE
  } state_t;

  state_t state;
  logic [1:0]    step;
  logic          dbl;
  logic [n-1:0]  pr, ar, x1r, y1r, x2r, y2r, y2n;
  logic [n-1:0]  num, den, inv, lam, tmp, x3t, y3t;
  logic [n-1:0]  inv_u, inv_v, inv_c1, inv_c2;
  logic [IW-1:0] inv_iter;
  logic [n-1:0]  mul_a, mul_b, mul_acc;
  logic [CW-1:0] mul_cnt;
  logic [n-1:0]  mul_red, mul_next;
  logic          finite_done;
  logic          operand_bad;

  function automatic logic [n-1:0] mod_add(input logic [n-1:0] fa, input logic [n-1:0] fb,
                                           input logic [n-1:0] fm);
    logic [n:0] fs;
    fs = {1'b0, fa} + {1'b0, fb};
    if (fs >= {1'b0, fm}) fs = fs - {1'b0, fm};
    return fs[n-1:0];
  endfunction

  function automatic logic [n-1:0] mod_sub(input logic [n-1:0] fa, input logic [n-1:0] fb,
                                           input logic [n-1:0] fm);
    logic [n:0] fs;
    if (fa >= fb) fs = {1'b0, fa} - {1'b0, fb};
    else          fs = {1'b0, fa} + {1'b0, fm} - {1'b0, fb};
    return fs[n-1:0];
  endfunction

  // Division by two mod an odd modulus: add the modulus first when the value is odd.
  function automatic logic [n-1:0] mod_half(input logic [n-1:0] fa, input logic [n-1:0] fm);
    logic [n:0] fs;
    fs = fa[0] ? ({1'b0, fa} + {1'b0, fm}) : {1'b0, fa};
    return fs[n:1];
  endfunction

  // One MSB-first step of the interleaved modular multiplier: acc = 2*acc + bit*a (mod p).
  assign mul_red  = mod_add(mul_acc, mul_acc, pr);
  assign mul_next = mod_add(mul_red, mul_b[n-1] ? mul_a : '0, pr);

`ifdef POINT_SUB_RANGE_CHECK_EN
  assign operand_bad = (x1 >= p) || (y1 >= p) || (x2 >= p) || (y2 >= p) || (a >= p);
  assign finite_done = !infinity && !range_err;
`else
  assign operand_bad = 1'b0;
  assign finite_done = !infinity;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      step         <= '0;
      dbl          <= 1'b0;
      pr           <= '0;
      ar           <= '0;
      x1r          <= '0;
      y1r          <= '0;
      x2r          <= '0;
      y2r          <= '0;
      y2n          <= '0;
      num          <= '0;
      den          <= '0;
      inv          <= '0;
      lam          <= '0;
      tmp          <= '0;
      x3t          <= '0;
      y3t          <= '0;
      inv_u        <= '0;
      inv_v        <= '0;
      inv_c1       <= '0;
      inv_c2       <= '0;
      inv_iter     <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_acc      <= '0;
      mul_cnt      <= '0;
      x3           <= '0;
      y3           <= '0;
      result_ready <= 1'b0;
      infinity     <= 1'b0;
      busy         <= 1'b0;
`ifdef POINT_SUB_RANGE_CHECK_EN
      range_err    <= 1'b0;
`endif
    end else begin
      if (mul_cnt != '0) begin
        mul_acc <= mul_next;
        mul_b   <= {mul_b[n-2:0], 1'b0};
        mul_cnt <= mul_cnt - CW'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            pr           <= p;
            ar           <= a;
            x1r          <= x1;
            y1r          <= y1;
            x2r          <= x2;
            y2r          <= y2;
            result_ready <= 1'b0;
            infinity     <= 1'b0;
            busy         <= 1'b1;
            step         <= '0;
`ifdef POINT_SUB_RANGE_CHECK_EN
            range_err    <= operand_bad;
`endif
            state        <= operand_bad ? DONE : NEG;
          end
        end

        NEG: begin
          y2n   <= (y2r == '0) ? '0 : pr - y2r;
          state <= CLASSIFY;
        end

        CLASSIFY: begin
          step <= '0;
          if (x1r != x2r) begin
            dbl   <= 1'b0;
            state <= NUM;
          end else if (y1r != y2r && y1r == y2n && y1r != '0) begin
            dbl   <= 1'b1;
            state <= NUM;
          end else begin
            state <= INF;
          end
        end

        INF: begin
          infinity     <= 1'b1;
          result_ready <= 1'b0;
          x3           <= '0;
          y3           <= '0;
          state        <= DONE;
        end

        // Chord slope for distinct x, tangent slope (3x^2 + a) / 2y for P = -Q.
        NUM: begin
          if (!dbl) begin
            num   <= mod_sub(y2n, y1r, pr);
            den   <= mod_sub(x2r, x1r, pr);
            step  <= '0;
            state <= INV;
          end else if (step == 2'd0) begin
            mul_a   <= x1r;
            mul_b   <= x1r;
            mul_acc <= '0;
            mul_cnt <= CW'(n);
            step    <= 2'd1;
          end else if (step == 2'd1) begin
            if (mul_cnt == '0) begin
              num  <= mod_add(mul_acc, mod_add(mul_acc, mul_acc, pr), pr);
              step <= 2'd2;
            end
          end else begin
            num   <= mod_add(num, ar, pr);
            den   <= mod_add(y1r, y1r, pr);
            step  <= '0;
            state <= INV;
          end
        end

        // Binary extended Euclid keeping c1*den = u and c2*den = v (mod p); each step drops a bit.
        INV: begin
          if (step == 2'd0) begin
            inv_u    <= den;
            inv_v    <= pr;
            inv_c1   <= n'(1);
            inv_c2   <= '0;
            inv_iter <= '0;
            step     <= 2'd1;
          end else if (inv_u == n'(1)) begin
            inv   <= inv_c1;
            step  <= '0;
            state <= LAMBDA;
          end else if (inv_v == n'(1)) begin
            inv   <= inv_c2;
            step  <= '0;
            state <= LAMBDA;
          end else if (inv_iter >= IW'(2 * n)) begin
            inv   <= '0;
            step  <= '0;
            state <= LAMBDA;
          end else begin
            inv_iter <= inv_iter + IW'(1);
            if (!inv_u[0]) begin
              inv_u  <= inv_u >> 1;
              inv_c1 <= mod_half(inv_c1, pr);
            end else if (!inv_v[0]) begin
              inv_v  <= inv_v >> 1;
              inv_c2 <= mod_half(inv_c2, pr);
            end else if (inv_u > inv_v) begin
              inv_u  <= (inv_u - inv_v) >> 1;
              inv_c1 <= mod_half(mod_sub(inv_c1, inv_c2, pr), pr);
            end else begin
              inv_v  <= (inv_v - inv_u) >> 1;
              inv_c2 <= mod_half(mod_sub(inv_c2, inv_c1, pr), pr);
            end
          end
        end

        LAMBDA: begin
          if (step == 2'd0) begin
            mul_a   <= num;
            mul_b   <= inv;
            mul_acc <= '0;
            mul_cnt <= CW'(n);
            step    <= 2'd1;
          end else if (mul_cnt == '0) begin
            lam   <= mul_acc;
            step  <= '0;
            state <= X3;
          end
        end

        X3: begin
          if (step == 2'd0) begin
            mul_a   <= lam;
            mul_b   <= lam;
            mul_acc <= '0;
            mul_cnt <= CW'(n);
            step    <= 2'd1;
          end else if (step == 2'd1) begin
            if (mul_cnt == '0) begin
              tmp  <= mod_sub(mul_acc, x1r, pr);
              step <= 2'd2;
            end
          end else begin
            x3t   <= mod_sub(tmp, x2r, pr);
            step  <= '0;
            state <= Y3;
          end
        end

        Y3: begin
          if (step == 2'd0) begin
            tmp  <= mod_sub(x1r, x3t, pr);
            step <= 2'd1;
          end else if (step == 2'd1) begin
            mul_a   <= lam;
            mul_b   <= tmp;
            mul_acc <= '0;
            mul_cnt <= CW'(n);
            step    <= 2'd2;
          end else if (mul_cnt == '0) begin
            y3t   <= mod_sub(mul_acc, y1r, pr);
            step  <= '0;
            state <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (finite_done) begin
            x3           <= x3t;
            y3           <= y3t;
            result_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_point_subtraction.sv
// Directed testbench for point_subtraction on y^2 = x^3 + 2x + 2 over GF(17), G = (5,1).
module tb_point_subtraction;
  localparam int n = 10;
  localparam int LAT_LIMIT = 8 * n + 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [n-1:0] p = n'(17);
  logic [n-1:0] a = n'(2);
  logic [n-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic [n-1:0] x3, y3;
  logic         result_ready, infinity, busy;
`ifdef POINT_SUB_RANGE_CHECK_EN
  logic         range_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  point_subtraction #(.n(n)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .p            (p),
    .a            (a),
    .x1           (x1),
    .y1           (y1),
    .x2           (x2),
    .y2           (y2),
    .x3           (x3),
    .y3           (y3),
    .result_ready (result_ready),
    .infinity     (infinity),
`ifdef POINT_SUB_RANGE_CHECK_EN
    .range_err    (range_err),
`endif
    .busy         (busy)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives operands and a one-cycle start; returns on the falling edge after the accepting edge.
  task automatic applyStimulus(input int px1, input int py1, input int px2, input int py2);
    @(negedge clk);
    x1 = n'(px1);
    y1 = n'(py1);
    x2 = n'(px2);
    y2 = n'(py2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitResult(input int budget, output int cycles);
    cycles = 0;
    while (!(result_ready || infinity) && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic runCase(input string tag, input int px1, input int py1, input int px2,
                         input int py2, input int ex3, input int ey3, input int erdy,
                         input int einf, input int limit);
    int cyc;
    applyStimulus(px1, py1, px2, py2);
    checkOutput({tag, "_busy_hi"}, int'(busy), 1);
    waitResult(200, cyc);
    checkOutput({tag, "_completed"}, int'(result_ready || infinity), 1);
    checkOutput({tag, "_latency_ok"}, int'(cyc <= limit), 1);
    checkOutput({tag, "_x3"}, int'(x3), ex3);
    checkOutput({tag, "_y3"}, int'(y3), ey3);
    checkOutput({tag, "_result_ready"}, int'(result_ready), erdy);
    checkOutput({tag, "_infinity"}, int'(infinity), einf);
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "_busy_lo"}, int'(busy), 0);
    checkOutput({tag, "_hold_x3"}, int'(x3), ex3);
  endtask

  initial begin
    int cyc;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_x3", int'(x3), 0);
    checkOutput("reset_y3", int'(y3), 0);
    checkOutput("reset_result_ready", int'(result_ready), 0);
    checkOutput("reset_infinity", int'(infinity), 0);
    checkOutput("reset_busy", int'(busy), 0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] case 1: (6,3) - (5,1)");
    runCase("c1", 6, 3, 5, 1, 5, 1, 1, 0, LAT_LIMIT);
    $display("[TB] case 2: (10,6) - (6,3)");
    runCase("c2", 10, 6, 6, 3, 5, 1, 1, 0, LAT_LIMIT);
    $display("[TB] case 4: (5,1) - (5,1)");
    runCase("c4", 5, 1, 5, 1, 0, 0, 0, 1, 4);
    $display("[TB] case 3: (5,1) - (5,16) doubling");
    runCase("c3", 5, 1, 5, 16, 6, 3, 1, 0, LAT_LIMIT);

    $display("[TB] case 5: reset mid-operation and ignored restart");
    applyStimulus(10, 6, 6, 3);
    repeat (20) @(negedge clk);
    checkOutput("c5_busy_before_reset", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("c5_rst_x3", int'(x3), 0);
    checkOutput("c5_rst_y3", int'(y3), 0);
    checkOutput("c5_rst_result_ready", int'(result_ready), 0);
    checkOutput("c5_rst_infinity", int'(infinity), 0);
    checkOutput("c5_rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("c5_idle_after_release", int'(busy), 0);
    checkOutput("c5_no_result_after_release", int'(result_ready), 0);

    applyStimulus(6, 3, 5, 1);
    repeat (5) @(negedge clk);
    x1 = n'(5);
    y1 = n'(1);
    x2 = n'(5);
    y2 = n'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("c5_busy_during_restart", int'(busy), 1);
    waitResult(200, cyc);
    checkOutput("c5_completed", int'(result_ready || infinity), 1);
    checkOutput("c5_x3", int'(x3), 5);
    checkOutput("c5_y3", int'(y3), 1);
    checkOutput("c5_result_ready", int'(result_ready), 1);
    checkOutput("c5_infinity", int'(infinity), 0);
    repeat (2) @(negedge clk);

`ifdef POINT_SUB_RANGE_CHECK_EN
    $display("[TB] case 6: operand range check");
    applyStimulus(17, 3, 5, 1);
    checkOutput("c6_range_err", int'(range_err), 1);
    checkOutput("c6_result_ready", int'(result_ready), 0);
    checkOutput("c6_infinity", int'(infinity), 0);
    @(negedge clk);
    checkOutput("c6_idle_after_2", int'(busy), 0);
    checkOutput("c6_x3_kept", int'(x3), 5);
    checkOutput("c6_y3_kept", int'(y3), 1);
    checkOutput("c6_range_err_hold", int'(range_err), 1);
    applyStimulus(6, 3, 5, 1);
    checkOutput("c6_range_err_clear", int'(range_err), 0);
    waitResult(200, cyc);
    checkOutput("c6_x3", int'(x3), 5);
    checkOutput("c6_y3", int'(y3), 1);
    checkOutput("c6_result_ready", int'(result_ready), 1);
    checkOutput("c6_range_err_final", int'(range_err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/point_subtraction.md
Name: point_subtraction

Overview:
- Computes R = P − Q on a short-Weierstrass curve y² = x³ + ax + b over GF(p), in affine coordinates.
- Method: internally negates Q (y → p − y), then performs affine addition, or doubling when P = −Q.
- Peer of the point-addition block; the scalar-multiplication datapath uses it for signed-digit (NAF) steps.
- Uses the same result_ready / infinity result interface as point addition, plus an explicit start handshake.

Parameters:
- n, 10, bit width of the prime, curve coefficient and every coordinate.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- p  in  n  odd prime modulus, p > 3.
- a  in  n  curve coefficient a, 0 ≤ a < p.
- x1, y1  in  n  point P.
- x2, y2  in  n  point Q.
- x3, y3  out  n  result R, registered.
- result_ready  out  1  high when R is valid and finite.
- infinity  out  1  high when R is the point at infinity.
- busy  out  1  high from the cycle after start is accepted until done.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While reset = 0: FSM forced to IDLE; x3, y3, result_ready, infinity, busy and all internal registers = 0.
- Reset mid-operation: the calculation is abandoned with no partial result. After release, the block waits for a fresh start.
- Start acceptance: start = 1 in IDLE latches p, a, x1, y1, x2, y2 and clears result_ready and infinity. start in any other state is ignored. Inputs may change freely after acceptance.
- FSM states: IDLE → NEG → CLASSIFY → {INF | NUM} → INV → LAMBDA → X3 → Y3 → DONE → IDLE.
- NEG: y2n = (y2 == 0) ? 0 : p − y2.
- CLASSIFY:
  - x1 ≠ x2: add path, num = y2n − y1, den = x2 − x1 (mod p).
  - x1 == x2 and y1 == y2: P = Q, go to INF.
  - x1 == x2 and y1 == y2n and y1 ≠ 0: double path, num = 3·x1² + a, den = 2·y1.
  - x1 == x2 and y1 == y2n and y1 == 0: go to INF.
- INF: infinity = 1, result_ready = 0, x3 = y3 = 0, then DONE.
- Modular multiply: sequential interleaved shift-add with conditional subtraction, MSB first. Exactly n cycles plus 1 setup cycle per product. Intermediate width is n+1 bits; never wider than n+2.
- Add/sub mod p: single cycle, one conditional correction.
- INV: binary extended-Euclid inverse of den. At most 2n iterations; den ≠ 0 is guaranteed by CLASSIFY.
- Result arithmetic:
  - λ = num·den⁻¹.
  - x3 = λ² − x1 − x2.
  - y3 = λ·(x1 − x3) − y1.
  - All values fully reduced to [0, p−1].
- DONE: on a finite result, x3/y3 update and result_ready = 1 in the same cycle; busy drops that cycle.
- Hold: outputs and flags stay stable until the next accepted start or reset. result_ready and infinity are never both 1.
- Latency: start edge to result_ready/infinity is ≤ 8n + 16 cycles. The INF path takes ≤ 4 cycles.
- Input range: coordinates must lie in [0, p−1] and be on the curve. Off-curve operands give an undefined but finite-time result, and the block always returns to IDLE.

Optional Feature:
- Macro: POINT_SUB_RANGE_CHECK_EN.
- Defined:
  - Adds output port range_err (1 bit, reset value 0).
  - If any of x1, y1, x2, y2 or a is ≥ p at start, the block sets range_err = 1 and result_ready = infinity = 0, leaves x3/y3 unchanged, returns to IDLE in 2 cycles, and performs no arithmetic.
  - range_err clears on the next accepted start.
- Undefined: no range_err port and no comparison logic; out-of-range inputs are undefined behaviour.

Test Plan:
All cases use p = 17, a = 2, on curve y² = x³ + 2x + 2, G = (5,1).
1. P = (6,3), Q = (5,1), start → result_ready = 1, R = (5,1), infinity = 0, latency ≤ 96 cycles.
2. P = (10,6), Q = (6,3) → R = (5,1). Exercises den = 13, inverse = 4, λ = 15.
3. P = (5,1), Q = (5,16), i.e. P = −Q, doubling path → R = (6,3), result_ready = 1.
4. P = (5,1), Q = (5,1) → infinity = 1, result_ready = 0, x3 = y3 = 0, within 4 cycles.
5. Reset and start interaction:
   - Start case 2, then pull reset low 20 cycles later → all outputs 0 and busy = 0 immediately.
   - Release reset, start case 1 → R = (5,1).
   - A second start pulsed while busy is ignored.
6. With POINT_SUB_RANGE_CHECK_EN defined: x1 = 17, start → range_err = 1, result_ready = 0, back in IDLE after 2 cycles. Next start with valid case 1 → range_err = 0, R = (5,1).
